register_file: RTL and testbench
================================

Name: register_file

Overview:
- Register file for the multi-cycle processor datapath: 16 general registers, 16 bits each.
- Two read ports (A, B) and one write port.
- Writes are synchronous.
- Read ports are output registers loaded only on cycles where the read enable is asserted; they hold their value otherwise.
- Sits between the decode/operand-fetch stage and the ALU/writeback path.

Parameters:
- DATA_W, 16, width of each register and of every data bus.
- ADDR_W, 4, register address width.
- NUM_REGS, 16, number of registers; must equal 2**ADDR_W.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- RA  input  ADDR_W  read address, port A.
- RB  input  ADDR_W  read address, port B.
- RW  input  ADDR_W  write address.
- EnW  input  1  write enable.
- BusW  input  DATA_W  write data.
- En  input  1  read enable; loads BusA/BusB.
- BusA  output  DATA_W  registered read data, port A.
- BusB  output  DATA_W  registered read data, port B.

Behaviour:
- Reset, sampled on the rising clk edge:
  - all NUM_REGS registers clear to 0.
  - BusA and BusB clear to 0.
  - reset has priority over EnW and En in the same cycle.
- Write: on a rising edge with reset=0 and EnW=1, reg[RW] <= BusW. With EnW=0, no register changes.
- Read: on a rising edge with reset=0 and En=1, BusA <= reg[RA] and BusB <= reg[RB]. Latency is one edge from En sampled high.
- With En=0, BusA and BusB hold their last value, even if RA, RB or the addressed registers change.
- Read-during-write, same edge with En=1, EnW=1 and RA==RW: BusA takes BusW (write-through bypass). The same rule applies to port B when RB==RW. Non-matching ports read the old array contents.
- A write followed by a read enable on the next edge returns the new data.
- RA may equal RB; both ports then return the same value.
- All addresses 0..15 are valid. There is no out-of-range case. Register 0 is an ordinary register unless the optional feature is enabled.
- Outputs never change between clock edges. No combinational path from any input to BusA/BusB.
- There are no X outputs after the first reset. Before the first reset, contents are undefined.

Optional Feature:
- Macro: REGFILE_R0_ZERO_EN.
- When defined:
  - register 0 is hardwired to 0.
  - writes with RW=0 are ignored.
  - reads of address 0 return 0.
  - the bypass does not apply when RW=0, so a read of address 0 returns 0 even during a write to address 0.
- When undefined: register 0 behaves like every other register.

Test Plan:
- Reset then read: assert reset for 1 cycle, then En=1, RA=5, RB=15 -> BusA=0000, BusB=0000 after one edge; every register reads 0.
- Write then read:
  - RW=2, BusW=A5A5, EnW=1 for one edge, then EnW=0.
  - Then En=1, RA=2, RB=3 for one edge, then En=0.
  - Required: BusA=A5A5, BusB=0000, and both values hold after En drops.
- Hold with En=0: after the previous step, write reg2=1234 with En=0 -> BusA stays A5A5 until En=1, then becomes 1234.
- Write-through bypass: EnW=1, En=1, RW=RA=7, RB=8 (reg8=0BEE), BusW=CAFE on the same edge -> BusA=CAFE, BusB=0BEE, reg7=CAFE afterwards.
- Reset priority: reset=1 with EnW=1, RW=4, BusW=FFFF, En=1 -> reg4=0000 and BusA=BusB=0000 after the edge.
- Optional feature, REGFILE_R0_ZERO_EN defined: write RW=0, BusW=DEAD, then read RA=0 -> BusA=0000; with the macro undefined, the same sequence gives BusA=DEAD.

Source files
------------

// File: rtl/register_file.sv
// register_file: a 16 x 16-bit register file for the multi-cycle datapath.
// It has two registered read ports (A, B), each loaded only while En is high,
// and one synchronous write port. A read of an address that is being written
// on the same edge returns the incoming write data.
// Optional feature macro: REGFILE_R0_ZERO_EN. When it is defined, register 0
// always reads as zero and writes to it are dropped.
module register_file #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] RA,
    input  logic [ADDR_W-1:0] RB,
    input  logic [ADDR_W-1:0] RW,
    input  logic              EnW,
    input  logic [DATA_W-1:0] BusW,
    input  logic              En,
    output logic [DATA_W-1:0] BusA,
    output logic [DATA_W-1:0] BusB
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              write_ok;
    logic [DATA_W-1:0] next_a;
    logic [DATA_W-1:0] next_b;

    // Qualify the write: with r0 hardwired, a write aimed at address 0 is dropped entirely
    always_comb begin
        write_ok = EnW;
`ifdef REGFILE_R0_ZERO_EN
        if (RW == '0) begin
            write_ok = 1'b0;
        end
`endif
    end

    // Select the read data for each port, forwarding BusW when the write hits the same address
    always_comb begin
        next_a = regs[RA];
        next_b = regs[RB];
        if (write_ok && (RW == RA)) begin
            next_a = BusW;
        end
        if (write_ok && (RW == RB)) begin
            next_b = BusW;
        end
`ifdef REGFILE_R0_ZERO_EN
        if (RA == '0) begin
            next_a = '0;
        end
        if (RB == '0) begin
            next_b = '0;
        end
`endif
    end

    // Register array: reset clears every entry; otherwise a qualified write updates one entry
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_ok) begin
            regs[RW] <= BusW;
        end
    end

    // Output registers: load on En, otherwise hold, so nothing reaches BusA/BusB between edges
    always_ff @(posedge clk) begin
        if (reset) begin
            BusA <= '0;
            BusB <= '0;
        end else if (En) begin
            BusA <= next_a;
            BusB <= next_b;
        end
    end

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed scenarios plus randomized traffic for register_file.
// Expected values come from directed constants and from a behavioural array model.
module tb_register_file;

`ifdef REGFILE_R0_ZERO_EN
    localparam bit R0Z = 1'b1;
`else
    localparam bit R0Z = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  RA = '0;
    logic [3:0]  RB = '0;
    logic [3:0]  RW = '0;
    logic        EnW = 1'b0;
    logic [15:0] BusW = '0;
    logic        En = 1'b0;
    logic [15:0] BusA;
    logic [15:0] BusB;

    logic [15:0] mem [16];
    logic [15:0] expA;
    logic [15:0] expB;
    int tests = 0;
    int failed = 0;

    register_file dut (
        .clk(clk), .reset(reset), .RA(RA), .RB(RB), .RW(RW),
        .EnW(EnW), .BusW(BusW), .En(En), .BusA(BusA), .BusB(BusB)
    );

    always #5 clk = ~clk;

    // Reference model: the effect of one rising edge, from the current inputs.
    function automatic logic [15:0] model_read(input logic [3:0] addr);
        if (R0Z && addr == 4'd0) return 16'h0000;
        if (EnW && addr == RW && !(R0Z && RW == 4'd0)) return BusW;
        return mem[addr];
    endfunction

    task automatic cycle();
        if (reset) begin
            foreach (mem[i]) mem[i] = 16'h0000;
            expA = 16'h0000;
            expB = 16'h0000;
        end else begin
            if (En) begin
                expA = model_read(RA);
                expB = model_read(RB);
            end
            if (EnW && !(R0Z && RW == 4'd0)) mem[RW] = BusW;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 1'b0; EnW = 1'b0; En = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; EnW = 1'b1; RW = 4'd9; BusW = 16'h5555; En = 1'b1;
        cycle();
        idle();
        tests++;
        if (BusA !== 16'h0000 || BusB !== 16'h0000) begin
            $display("[TB] FAIL reset_outputs BusA=%h BusB=%h expected 0000/0000", BusA, BusB);
            failed++;
        end
        RA = 4'd5; RB = 4'd15; En = 1'b1;
        cycle();
        tests++;
        if (BusA !== 16'h0000 || BusB !== 16'h0000) begin
            $display("[TB] FAIL reset_read_5_15 BusA=%h BusB=%h expected 0000/0000", BusA, BusB);
            failed++;
        end
        for (int i = 0; i < 8; i++) begin
            RA = 4'(2 * i); RB = 4'(2 * i + 1); En = 1'b1;
            cycle();
            tests++;
            if (BusA !== 16'h0000 || BusB !== 16'h0000) begin
                $display("[TB] FAIL reset_sweep r%0d BusA=%h BusB=%h expected 0000/0000", 2 * i, BusA, BusB);
                failed++;
            end
        end
        idle();
    endtask

    task automatic test_write_read();
        RW = 4'd2; BusW = 16'hA5A5; EnW = 1'b1; En = 1'b0;
        cycle();
        EnW = 1'b0; RA = 4'd2; RB = 4'd3; En = 1'b1;
        cycle();
        tests++;
        if (BusA !== 16'hA5A5 || BusB !== 16'h0000) begin
            $display("[TB] FAIL write_read BusA=%h BusB=%h expected a5a5/0000", BusA, BusB);
            failed++;
        end
        En = 1'b0; RA = 4'd3; RB = 4'd2;
        cycle();
        tests++;
        if (BusA !== 16'hA5A5 || BusB !== 16'h0000) begin
            $display("[TB] FAIL write_read_hold BusA=%h BusB=%h expected a5a5/0000", BusA, BusB);
            failed++;
        end
    endtask

    task automatic test_hold();
        RA = 4'd2; RB = 4'd3;
        RW = 4'd2; BusW = 16'h1234; EnW = 1'b1; En = 1'b0;
        cycle();
        EnW = 1'b0;
        cycle();
        tests++;
        if (BusA !== 16'hA5A5) begin
            $display("[TB] FAIL hold_en0 BusA=%h expected a5a5", BusA);
            failed++;
        end
        En = 1'b1;
        cycle();
        En = 1'b0;
        tests++;
        if (BusA !== 16'h1234) begin
            $display("[TB] FAIL hold_reload BusA=%h expected 1234", BusA);
            failed++;
        end
    endtask

    task automatic test_bypass();
        RW = 4'd8; BusW = 16'h0BEE; EnW = 1'b1; En = 1'b0;
        cycle();
        RW = 4'd7; RA = 4'd7; RB = 4'd8; BusW = 16'hCAFE; EnW = 1'b1; En = 1'b1;
        cycle();
        tests++;
        if (BusA !== 16'hCAFE || BusB !== 16'h0BEE) begin
            $display("[TB] FAIL bypass BusA=%h BusB=%h expected cafe/0bee", BusA, BusB);
            failed++;
        end
        EnW = 1'b0; RA = 4'd7; RB = 4'd7; En = 1'b1;
        cycle();
        En = 1'b0;
        tests++;
        if (BusA !== 16'hCAFE || BusB !== 16'hCAFE) begin
            $display("[TB] FAIL bypass_stored_ra_eq_rb BusA=%h BusB=%h expected cafe/cafe", BusA, BusB);
            failed++;
        end
    endtask

    task automatic test_reset_priority();
        RW = 4'd4; BusW = 16'h1111; EnW = 1'b1; En = 1'b0;
        cycle();
        EnW = 1'b0; RA = 4'd4; RB = 4'd7; En = 1'b1;
        cycle();
        reset = 1'b1; EnW = 1'b1; RW = 4'd4; BusW = 16'hFFFF; En = 1'b1;
        cycle();
        reset = 1'b0; EnW = 1'b0; En = 1'b0;
        tests++;
        if (BusA !== 16'h0000 || BusB !== 16'h0000) begin
            $display("[TB] FAIL reset_priority_bus BusA=%h BusB=%h expected 0000/0000", BusA, BusB);
            failed++;
        end
        En = 1'b1;
        cycle();
        En = 1'b0;
        tests++;
        if (BusA !== 16'h0000 || BusB !== 16'h0000) begin
            $display("[TB] FAIL reset_priority_reg4 BusA=%h BusB=%h expected 0000/0000", BusA, BusB);
            failed++;
        end
    endtask

    task automatic test_r0();
        logic [15:0] want;
        RW = 4'd0; BusW = 16'hDEAD; EnW = 1'b1; En = 1'b0;
        cycle();
        EnW = 1'b0; RA = 4'd0; RB = 4'd0; En = 1'b1;
        cycle();
        want = R0Z ? 16'h0000 : 16'hDEAD;
        tests++;
        if (BusA !== want || BusB !== want) begin
            $display("[TB] FAIL r0_write_read BusA=%h BusB=%h expected %h", BusA, BusB, want);
            failed++;
        end
        RW = 4'd0; BusW = 16'hBEEF; EnW = 1'b1; RA = 4'd0; RB = 4'd1; En = 1'b1;
        cycle();
        idle();
        want = R0Z ? 16'h0000 : 16'hBEEF;
        tests++;
        if (BusA !== want || BusB !== 16'h0000) begin
            $display("[TB] FAIL r0_bypass BusA=%h BusB=%h expected %h/0000", BusA, BusB, want);
            failed++;
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 49) == 0);
            RA    = 4'($urandom_range(0, 15));
            RB    = ($urandom_range(0, 7) == 0) ? RA : 4'($urandom_range(0, 15));
            RW    = ($urandom_range(0, 3) == 0) ? RA : 4'($urandom_range(0, 15));
            EnW   = 1'($urandom_range(0, 1));
            En    = 1'($urandom_range(0, 1));
            BusW  = 16'($urandom());
            cycle();
            tests++;
            if (BusA !== expA || BusB !== expB) begin
                $display("[TB] FAIL random_%0d BusA=%h BusB=%h expected %h/%h", n, BusA, BusB, expA, expB);
                failed++;
            end
        end
        idle();
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_write_read();
        test_hold();
        test_bypass();
        test_reset_priority();
        test_r0();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
